// File: rtl/sync_down_timer.sv
// Synchronous loadable down-counter with one-shot / periodic terminal-count pulse.
// Optional prescaler enabled by defining DOWN_TIMER_PRESCALE_EN.
module sync_down_timer #(
  parameter int WIDTH    = 4,
  parameter int PRESCALE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             stop,
  input  logic             en,
  input  logic             mode,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] reload;
  logic             step;
  logic             start_ok;

  assign start_ok = start && (state != RUN);

`ifdef DOWN_TIMER_PRESCALE_EN
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PW-1:0] presc;

  assign step = (presc == PW'(PRESCALE - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc <= '0;
    end else if (load || stop || start_ok) begin
      presc <= '0;
    end else if (state == RUN && en) begin
      presc <= step ? '0 : presc + 1'b1;
    end
  end
`else
  assign step = 1'b1;
`endif

  // busy/done are kept as flops beside state so every output leaves a register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: async reset sits in the sensitivity list; state uses <= so all flops update together.
      state  <= IDLE;
      count  <= '0;
      reload <= '0;
      tc     <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      tc <= 1'b0;
      if (load) begin
        reload <= load_val;
        count  <= load_val;
        state  <= IDLE;
        busy   <= 1'b0;
        done   <= 1'b0;
      end else if (stop) begin
        state <= IDLE;
        busy  <= 1'b0;
        done  <= 1'b0;
      end else if (start_ok) begin
        if (reload != '0) begin
          count <= reload;
          state <= RUN;
          busy  <= 1'b1;
          done  <= 1'b0;
        end else begin
          count <= '0;
          state <= DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
          tc    <= 1'b1;
        end
      end else if (state == RUN && en && step) begin
        if (count > WIDTH'(1)) begin
          count <= count - 1'b1;
        end else begin
          tc <= 1'b1;
          if (mode) begin
            count <= reload;
          end else begin
            count <= '0;
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: doc/sync_down_timer.md
Name: sync_down_timer

Overview:
- Synchronous, loadable down-counter/timer. It is the complement of the team's ripple up-counter: it counts toward zero instead of away from it.
- All flops share one clock, so there are no ripple-clock paths.
- Provides a one-shot or periodic terminal-count pulse that drives timeouts, tick generation and delay sequencing elsewhere in the design.

Parameters:
WIDTH, 4, counter and reload register width in bits (min 2)
PRESCALE, 4, enabled cycles per decrement; used only when DOWN_TIMER_PRESCALE_EN is defined (min 1)

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-low
load  input  1  capture load_val into reload register and counter
load_val  input  WIDTH  reload value
start  input  1  begin counting from reload value
stop  input  1  abort count, return to IDLE
en  input  1  count enable (qualifies decrement)
mode  input  1  0 = one-shot, 1 = periodic auto-reload
count  output  WIDTH  current counter value
tc  output  1  terminal-count pulse, one cycle
busy  output  1  high in RUN
done  output  1  high in DONE

Behaviour:
- Reset (rst=0, async): count=0, reload register=0, state=IDLE, tc=0, busy=0, done=0. This applies immediately, including mid-RUN.
- Sync priority per edge: load > stop > start > decrement.
- States: IDLE, RUN, DONE. Outputs are decoded from state: busy = (state==RUN), done = (state==DONE).
- All outputs are registered. A change caused at edge N is visible after edge N.
- load (any state):
  - reload <= load_val, count <= load_val, state <= IDLE, tc <= 0.
  - A start in the same cycle is ignored.
- stop (any state): state <= IDLE; count holds its value; tc <= 0.
- start in IDLE or DONE:
  - If reload != 0: count <= reload, state <= RUN.
  - If reload == 0: state <= DONE, tc <= 1 for one cycle, in either mode. Periodic with zero reload degenerates to one-shot.
- start while in RUN: ignored (no retrigger).
- RUN with en=0: count holds, tc=0.
- RUN with en=1 and count > 1: count <= count-1.
- RUN with en=1 and count == 1: tc <= 1, then:
  - mode=0: count <= 0, state <= DONE.
  - mode=1: count <= reload, stay in RUN.
- Period: reload enabled cycles per tc. With reload=1 and mode=1, tc is high on every enabled cycle and count stays 1.
- mode is sampled at the count==1 decision point. Changing mode mid-run affects only the next terminal event.
- tc defaults to 0 every cycle; it is never high for two consecutive cycles except in the reload=1 periodic case.
- DONE: count holds 0. Exit via start (restart), load, or stop.
- No wrap-around: count never decrements below 0.
- Arithmetic is unsigned, WIDTH bits. Maximum reload is 2^WIDTH-1.

Optional Feature:
- Macro: DOWN_TIMER_PRESCALE_EN.
- Defined:
  - An internal prescale counter counts enabled RUN cycles.
  - A decrement/terminal decision happens only on every PRESCALE-th enabled cycle, so the effective period is reload*PRESCALE enabled cycles.
  - The prescaler clears on reset, load, stop, start and at each decrement.
  - en=0 freezes the prescaler.
- Undefined: every enabled RUN cycle decrements, as if PRESCALE=1. No prescale logic is synthesized.

Test Plan:
1. One-shot:
   - Stimulus: load load_val=5, then start with mode=0, en=1 held.
   - Response: count 5,4,3,2,1,0 on successive cycles; tc=1 for exactly the cycle count first reads 0; done=1, busy=0 thereafter; count stays 0.
2. Periodic:
   - Stimulus: load 3, start with mode=1, en=1 held for 10 cycles.
   - Response: count sequence 3,2,1,3,2,1,3,2,1,3; tc pulses when count reloads to 3, once every 3 cycles; busy stays 1.
3. Enable gating:
   - Stimulus: load 4, start, en toggling 1,0,1,0...
   - Response: count decrements only after en=1 cycles (4,3,3,2,2,1,1,0); tc fires once.
4. Zero reload:
   - Stimulus: load 0, start with mode=1.
   - Response: next cycle done=1, tc=1 for one cycle, busy never asserts.
5. Priority and abort:
   - Stimulus A: load=1 and start=1 in the same cycle. Response: state IDLE, count=load_val.
   - Stimulus B: stop at count=2 in RUN. Response: IDLE, count holds 2, no tc.
   - Stimulus C: start while in RUN. Response: ignored.
6. Async reset mid-run:
   - Stimulus: rst=0 asserted between clock edges at count=6.
   - Response: count=0, busy=0, tc=0 immediately, without waiting for a clock edge. After rst=1, start with reload 0 gives DONE.
